io_port: RTL
============

IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter WIDTH, default 16, sets the accumulator width; the character width is fixed at 8.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ac_in  input  WIDTH  accumulator value; only bits [7:0] are used.
REQ-005 inp_en, out_en, ski_en, sko_en, ion_en, iof_en  input  1 each  one-cycle instruction strobes from the controller, at most one high per cycle.
REQ-006 clr_r  input  1  controller acknowledges the interrupt cycle and clears R.
REQ-007 inpr  output  8  input register, presented to the controller for AC(7:0) <- INPR.
REQ-008 fgi, fgo, ien, r_flag  output  1 each  input flag, output flag, interrupt enable and interrupt request flip-flop.
REQ-009 skip  output  1  combinational; high when ski_en&fgi or sko_en&fgo.
REQ-010 dev_in_data  input  8; dev_in_valid  input  1; dev_in_ready  output  1  keyboard-side valid/ready channel.
REQ-011 dev_out_data  output  8; dev_out_valid  output  1; dev_out_ready  input  1  printer-side valid/ready channel.

Function
REQ-012 The input side shall drive dev_in_ready = ~fgi, and a transfer occurs when dev_in_valid & dev_in_ready are both high.
REQ-013 On an input transfer, inpr shall load dev_in_data and fgi shall be set to 1 on the same edge.
REQ-014 inp_en shall clear fgi on the next edge; inpr holds its value.
REQ-015 If inp_en and an input transfer coincide, fgi shall be cleared and the new byte discarded; this cannot occur while fgi=1 because dev_in_ready is low.
REQ-016 The output side shall be a two-state FSM: IDLE (fgo=1, dev_out_valid=0) and SEND (fgo=0, dev_out_valid=1).
REQ-017 In IDLE, out_en shall load OUTR from ac_in[7:0], clear fgo and enter SEND on the next edge.
REQ-018 In SEND, dev_out_data shall equal OUTR and remain stable until dev_out_ready is sampled high; then the FSM enters IDLE and sets fgo.
REQ-019 out_en in SEND shall be ignored, leaving OUTR unchanged; software must poll fgo first.
REQ-020 ion_en shall set ien; iof_en shall clear ien.
REQ-021 r_flag shall set on an edge where ien & (fgi | fgo) holds and clr_r is low.
REQ-022 clr_r shall clear both r_flag and ien, and clr_r has priority over setting r_flag.
REQ-023 Strobe-to-flag latency shall be 1 cycle, and skip shall have 0-cycle latency.

Reset
REQ-024 When rst is high, the block shall force inpr=0, OUTR=0, fgi=0, fgo=1, ien=0 and r_flag=0, and put the FSM in IDLE.
REQ-025 Reset shall win over every simultaneous strobe or handshake.
REQ-026 Reset in SEND shall drop dev_out_valid on the next edge and abandon the character.

Configuration
REQ-027 The macro IO_PORT_IRQ_EN shall control whether interrupt support is compiled in.
REQ-028 With IO_PORT_IRQ_EN defined, the block shall implement REQ-020 to REQ-022.
REQ-029 Without IO_PORT_IRQ_EN, ien and r_flag shall be tied to 0, and ion_en, iof_en and clr_r shall be ignored; the rest of the block is unchanged.

Structure
REQ-030 A shared package shall hold the character width constant (8), the output-FSM state enum (IDLE, SEND) and the I/O opcode bit positions IR[11:6] (INP=11, OUT=10, SKI=9, SKO=8, ION=7, IOF=6).
REQ-031 One sub-module, io_out_fsm, shall own OUTR, fgo and the printer handshake; everything else stays in io_port.

Verification
REQ-032 Reset test: pulse rst -> next cycle fgo=1, fgi=0, inpr=0x00, dev_in_ready=1, dev_out_valid=0.
REQ-033 Input test: dev_in_valid=1 with 0x41 -> next edge inpr=0x41, fgi=1, dev_in_ready=0; then inp_en -> fgi=0; a second byte 0x42 is accepted only afterwards.
REQ-034 Output test: ac_in=0x1234, out_en -> dev_out_data=0x34, dev_out_valid=1, fgo=0; hold dev_out_ready=0 for 5 cycles -> data stable; dev_out_ready=1 -> next edge fgo=1, valid=0.
REQ-035 Skip test: fgi=1 with ski_en -> skip=1 in the same cycle; fgo=0 (SEND) with sko_en -> skip=0.
REQ-036 Interrupt test (macro defined): ion_en, then a character arrives -> r_flag=1 one edge after fgi=1; clr_r -> r_flag=0, ien=0; with the macro undefined the same stimulus keeps r_flag=0.
REQ-037 Reset-mid-operation test: assert rst during SEND with dev_out_ready=0 -> next edge IDLE, fgo=1, dev_out_valid=0, OUTR=0.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared constants and types for the io_port block: character width,
// output FSM states and the I/O opcode bit positions within IR.
package io_port_pkg;

  localparam int unsigned CharWidth = 8;

  // Bit positions of the I/O opcodes within IR[11:6]
  localparam int unsigned IrInpBit = 11;
  localparam int unsigned IrOutBit = 10;
  localparam int unsigned IrSkiBit = 9;
  localparam int unsigned IrSkoBit = 8;
  localparam int unsigned IrIonBit = 7;
  localparam int unsigned IrIofBit = 6;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_port_if.sv
// Device-side valid/ready channels: keyboard into the port, port out to the printer.
// master = device side, slave = io_port side.
interface io_port_if;
  import io_port_pkg::*;

  logic [CharWidth-1:0] dev_in_data;
  logic                 dev_in_valid;
  logic                 dev_in_ready;
  logic [CharWidth-1:0] dev_out_data;
  logic                 dev_out_valid;
  logic                 dev_out_ready;

  modport master (
    output dev_in_data, dev_in_valid, dev_out_ready,
    input  dev_in_ready, dev_out_data, dev_out_valid
  );

  modport slave (
    input  dev_in_data, dev_in_valid, dev_out_ready,
    output dev_in_ready, dev_out_data, dev_out_valid
  );

endinterface

// File: rtl/io_out_fsm.sv
// Output side of the I/O port: owns OUTR, the FGO flag and the printer handshake.
module io_out_fsm
  import io_port_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 out_en,
  input  logic [CharWidth-1:0] ac_byte,
  input  logic                 dev_out_ready,
  output logic                 fgo,
  output logic                 dev_out_valid,
  output logic [CharWidth-1:0] dev_out_data
);

  out_state_e           state;
  logic [CharWidth-1:0] outr;

  // OUTR feeds the printer directly, so data is stable for the whole SEND state
  assign dev_out_data = outr;

  // Two-state FSM with registered flag and valid; out_en outside IDLE is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      outr          <= '0;
      fgo           <= 1'b1;
      dev_out_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (out_en) begin
            outr          <= ac_byte;
            fgo           <= 1'b0;
            dev_out_valid <= 1'b1;
            state         <= StSend;
          end
        end
        StSend: begin
          if (dev_out_ready) begin
            fgo           <= 1'b1;
            dev_out_valid <= 1'b0;
            state         <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/io_port.sv
// Basic-computer style I/O port: input register/flag, output FSM, skip logic
// and optional interrupt support selected by the IO_PORT_IRQ_EN macro.
module io_port
  import io_port_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     ac_in,
  input  logic                 inp_en,
  input  logic                 out_en,
  input  logic                 ski_en,
  input  logic                 sko_en,
  input  logic                 ion_en,
  input  logic                 iof_en,
  input  logic                 clr_r,
  output logic [CharWidth-1:0] inpr,
  output logic                 fgi,
  output logic                 fgo,
  output logic                 ien,
  output logic                 r_flag,
  output logic                 skip,
  io_port_if.slave             dev
);

  logic in_xfer;

  // Only the low character of AC is used by the port
  logic unused_ac;
  assign unused_ac = ^ac_in[WIDTH-1:CharWidth];

  assign dev.dev_in_ready = ~fgi;
  assign in_xfer          = dev.dev_in_valid & dev.dev_in_ready;

  assign skip = (ski_en & fgi) | (sko_en & fgo);

  // Input register and FGI; inp_en wins over a coincident transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else if (inp_en) begin
      fgi <= 1'b0;
    end else if (in_xfer) begin
      inpr <= dev.dev_in_data;
      fgi  <= 1'b1;
    end
  end

  io_out_fsm u_out_fsm (
    .clk           (clk),
    .rst           (rst),
    .out_en        (out_en),
    .ac_byte       (ac_in[CharWidth-1:0]),
    .dev_out_ready (dev.dev_out_ready),
    .fgo           (fgo),
    .dev_out_valid (dev.dev_out_valid),
    .dev_out_data  (dev.dev_out_data)
  );

`ifdef IO_PORT_IRQ_EN
  // Interrupt enable and request; clr_r clears both and beats any set
  always_ff @(posedge clk) begin
    if (rst) begin
      ien    <= 1'b0;
      r_flag <= 1'b0;
    end else if (clr_r) begin
      ien    <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      if (ion_en) begin
        ien <= 1'b1;
      end else if (iof_en) begin
        ien <= 1'b0;
      end
      if (ien && (fgi || fgo)) begin
        r_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_irq;
  assign unused_irq = ion_en ^ iof_en ^ clr_r;
  assign ien        = 1'b0;
  assign r_flag     = 1'b0;
`endif

endmodule
